// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Initiator side of the data-memory interface, placed between the MIPS
// execute/memory stage and DataMemory. It converts byte/halfword/word load and
// store requests into word-aligned memory accesses. Sub-word stores are done as
// read-modify-write. Load data is extracted and sign/zero extended here.
// Misaligned, out-of-range and illegal-size requests are flagged as faults and
// never touch memory.
//
// Parameters
//   MEM_WORDS  : data memory depth in 32-bit words; byte addresses at or above
//                MEM_WORDS*4 fault
//   BIG_ENDIAN : 1 -> byte offset 0 is bits [31:24]; 0 -> bits [7:0]
//
// Ports
//   clk, rst_n                : clock, asynchronous active-low reset
//   Req, Store, Size,
//   Unsigned, Addr, StoreData : CPU request, sampled only when idle
//   Busy                      : high while an access is in flight (stall)
//   Done, Fault               : one-cycle completion pulse and its fault flag
//   LoadData                  : extended load result, held until the next Done
//   MemRead, MemWrite,
//   Address, WriteData        : to DataMemory (Address always word aligned)
//   ReadData                  : from DataMemory, combinational
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_WORDS  = 1024,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req,
    input  logic        Store,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Busy,
    output logic        Done,
    output logic        Fault,
    output logic [31:0] LoadData,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [1:0]  SZ_BYTE   = 2'b00;
    localparam logic [1:0]  SZ_HALF   = 2'b01;
    localparam logic [1:0]  SZ_WORD   = 2'b10;
    // 33 bits so that MEM_WORDS*4 == 2**32 still compares correctly.
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    state_t      state_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        fault_reg;
    logic [31:0] load_data_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic [31:0] address_reg;
    logic [31:0] write_data_reg;

    // Request captured at acceptance.
    logic        store_reg;
    logic [1:0]  size_reg;
    logic        unsigned_reg;
    logic [1:0]  offset_reg;
    logic [31:0] store_data_reg;

    logic        req_fault;
    logic [4:0]  lane_shift;
    logic [31:0] rd_lane;
    logic [31:0] load_ext;
    logic [3:0]  lane_be;
    logic [31:0] st_lane;
    logic [31:0] merged;

    // Fault decode on the live request; only consumed when accepting.
    always_comb begin
        req_fault = 1'b0;
        if (Size == 2'b11)
            req_fault = 1'b1;
        else if (Size == SZ_HALF && Addr[0])
            req_fault = 1'b1;
        else if (Size == SZ_WORD && Addr[1:0] != 2'b00)
            req_fault = 1'b1;
        else if ({1'b0, Addr} >= MEM_BYTES)
            req_fault = 1'b1;
    end

    // Bit position of the addressed lane inside the memory word. Big-endian
    // reverses the byte numbering, hence the inverted offset.
    always_comb begin
        lane_shift = 5'd0;
        if (size_reg == SZ_BYTE)
            lane_shift = BIG_ENDIAN ? {~offset_reg, 3'b000} : {offset_reg, 3'b000};
        else if (size_reg == SZ_HALF)
            lane_shift = BIG_ENDIAN ? {~offset_reg[1], 4'b0000} : {offset_reg[1], 4'b0000};
    end

    always_comb begin
        rd_lane = ReadData >> lane_shift;
        case (size_reg)
            SZ_BYTE: load_ext = {{24{rd_lane[7]  & ~unsigned_reg}}, rd_lane[7:0]};
            SZ_HALF: load_ext = {{16{rd_lane[15] & ~unsigned_reg}}, rd_lane[15:0]};
            default: load_ext = rd_lane;
        endcase
        lane_be = ((size_reg == SZ_BYTE) ? 4'b0001 : 4'b0011) << lane_shift[4:3];
        st_lane = store_data_reg << lane_shift;
    end

    // Read-modify-write merge: enabled lanes take store data, the rest keep
    // the word just read.
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged[gi*8 +: 8] = lane_be[gi] ? st_lane[gi*8 +: 8] : ReadData[gi*8 +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            fault_reg      <= 1'b0;
            load_data_reg  <= 32'd0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            address_reg    <= 32'd0;
            write_data_reg <= 32'd0;
            store_reg      <= 1'b0;
            size_reg       <= 2'b00;
            unsigned_reg   <= 1'b0;
            offset_reg     <= 2'b00;
            store_data_reg <= 32'd0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            done_reg      <= 1'b0;
            fault_reg     <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Req) begin
                        store_reg      <= Store;
                        size_reg       <= Size;
                        unsigned_reg   <= Unsigned;
                        offset_reg     <= Addr[1:0];
                        store_data_reg <= StoreData;
                        busy_reg       <= 1'b1;
                        if (req_fault) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                            fault_reg <= 1'b1;
                        end else if (Store && Size == SZ_WORD) begin
                            state_reg      <= WRITE;
                            mem_write_reg  <= 1'b1;
                            address_reg    <= {Addr[31:2], 2'b00};
                            write_data_reg <= StoreData;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state_reg    <= READ;
                            mem_read_reg <= 1'b1;
                            address_reg  <= {Addr[31:2], 2'b00};
                        end
                    end
                end
                READ: begin
                    if (store_reg) begin
                        state_reg      <= WRITE;
                        mem_write_reg  <= 1'b1;
                        write_data_reg <= merged;
                    end else begin
                        state_reg     <= DONE;
                        done_reg      <= 1'b1;
                        load_data_reg <= load_ext;
                    end
                end
                WRITE: begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Busy      = busy_reg;
    assign Done      = done_reg;
    assign Fault     = fault_reg;
    assign LoadData  = load_data_reg;
    assign MemRead   = mem_read_reg;
    assign MemWrite  = mem_write_reg;
    assign Address   = address_reg;
    assign WriteData = write_data_reg;

endmodule
